// File: rtl/fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : fetch_seq
// Purpose  : rv32i instruction-fetch sequencer. Single-outstanding imem
//            requests, one-entry decode output register, EX-driven redirect.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_seq #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    input  logic            id_ready,
    input  logic            ex_valid,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    output logic            flush,
    output logic            misalign
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_req_pc, w_req_pc_nxt;
    logic            r_drop, w_drop_nxt;
    logic            r_misalign, w_misalign_nxt;
    logic            r_if_valid, w_if_valid_nxt;
    logic [31:0]     r_if_instr;
    logic [XLEN-1:0] r_if_pc;

    logic            w_redir, w_redir_act;
    logic [XLEN-1:0] w_sum_rel, w_sum_reg, w_target;
    logic            w_req, w_fire, w_load;

    assign w_redir     = ex_valid & ((pc_src == 2'd1) | (pc_src == 2'd2));
    assign w_redir_act = w_redir & (r_state != S_HALT);
    assign w_sum_rel   = ex_pc + ex_imm;
    assign w_sum_reg   = ex_rs1 + ex_imm;
    assign w_target    = (pc_src == 2'd2) ? {w_sum_reg[XLEN-1:1], 1'b0} : w_sum_rel;

    // A new request is only issued if its result has somewhere to land.
    assign w_req  = rst_n & (r_state == S_REQ) & (~r_if_valid | id_ready);
    assign w_fire = w_req & imem_gnt;
    assign w_load = (r_state == S_WAIT) & imem_rvalid & ~r_drop & ~w_redir_act;

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_req_pc_nxt   = r_req_pc;
        w_drop_nxt     = r_drop;
        w_misalign_nxt = r_misalign;
        w_if_valid_nxt = r_if_valid & ~id_ready;

        case (r_state)
            S_REQ: begin
                if (w_fire) begin
                    w_state_nxt  = S_WAIT;
                    w_req_pc_nxt = r_pc;
                    w_pc_nxt     = r_pc + XLEN'(4);
                    w_drop_nxt   = 1'b0;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    w_state_nxt = S_REQ;
                    w_drop_nxt  = 1'b0;
                end
            end
            S_HALT:  ;
            default: w_state_nxt = S_HALT;
        endcase

        if (w_load) begin
            w_if_valid_nxt = 1'b1;
        end

        // Redirect overrides sequential pc, any load, and marks in-flight work stale.
        if (w_redir_act) begin
            w_pc_nxt       = w_target;
            w_if_valid_nxt = 1'b0;
            if ((r_state == S_WAIT) && !imem_rvalid) begin
                w_drop_nxt = 1'b1;
            end
            if (w_fire) begin
                w_drop_nxt = 1'b1;
            end
            if (w_target[1]) begin
                w_misalign_nxt = 1'b1;
                w_state_nxt    = S_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_REQ;
            r_pc       <= RESET_PC;
            r_req_pc   <= RESET_PC;
            r_drop     <= 1'b0;
            r_misalign <= 1'b0;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_req_pc   <= w_req_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_misalign <= w_misalign_nxt;
            r_if_valid <= w_if_valid_nxt;
            if (w_load) begin
                r_if_instr <= imem_rdata;
                r_if_pc    <= r_req_pc;
            end
        end
    end

    assign imem_req  = w_req;
    assign imem_addr = r_pc;
    assign if_valid  = r_if_valid;
    assign if_instr  = r_if_instr;
    assign if_pc     = r_if_pc;
    assign flush     = w_redir;
    assign misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_seq
// Purpose  : Self-checking bench for fetch_seq: redirect table, directed
//            multi-cycle sequences and a randomized program-order scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_seq;

    localparam int          XLEN   = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          NV     = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        id_ready = 1'b1;
    logic        ex_valid = 1'b0;
    logic [1:0]  pc_src = 2'd0;
    logic [31:0] ex_pc = '0;
    logic [31:0] ex_imm = '0;
    logic [31:0] ex_rs1 = '0;
    logic        flush;
    logic        misalign;

    fetch_seq #(.XLEN(XLEN), .RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_gnt   (imem_gnt),
        .imem_rvalid(imem_rvalid),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .ex_valid   (ex_valid),
        .pc_src     (pc_src),
        .ex_pc      (ex_pc),
        .ex_imm     (ex_imm),
        .ex_rs1     (ex_rs1),
        .flush      (flush),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Memory responder knobs (written by the main sequence only)
    int gnt_pct = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit chk_inv = 1'b1;

    bit          resp_busy = 1'b0;
    logic [31:0] resp_addr = '0;
    int          resp_cnt  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory: grant at +3 after posedge, data 1..N cycles later.
    always begin
        @(posedge clk);
        #1;
        imem_rvalid = 1'b0;
        if (resp_busy) begin
            if (resp_cnt <= 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(resp_addr);
                resp_busy   = 1'b0;
            end else begin
                resp_cnt--;
            end
        end
        #2;
        imem_gnt = 1'b0;
        if (rst_n && imem_req) begin
            if (chk_inv) chkb("one_outstanding", resp_busy, 1'b0);
            chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            if (int'($urandom_range(99)) < gnt_pct) begin
                imem_gnt  = 1'b1;
                resp_busy = 1'b1;
                resp_addr = imem_addr;
                resp_cnt  = int'($urandom_range(lat_max, lat_min));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Returns at the sample point of the release cycle.
    task automatic do_reset();
        cyc();
        rst_n    = 1'b0;
        ex_valid = 1'b0;
        #3;
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_valid", if_valid, 1'b0);
        chk("rst_pc", if_pc, 32'h0);
        chk("rst_instr", if_instr, 32'h0);
        chkb("rst_misalign", misalign, 1'b0);
        repeat (3) cyc();
        rst_n = 1'b1;
        #3;
        chkb("rst_first_req", imem_req, 1'b1);
        chk("rst_first_addr", imem_addr, RST_PC);
    endtask

    task automatic wait_gnt(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            ex_valid = 1'b0;
            #3;
            seen = imem_req && imem_gnt;
        end
        chkb({name, "_timeout"}, seen, 1'b1);
    endtask

    task automatic wait_valid(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            ex_valid = 1'b0;
            #3;
            seen = if_valid;
        end
        chkb({name, "_timeout"}, seen, 1'b1);
    endtask

    typedef struct {
        logic        ev;
        logic [1:0]  src;
        logic [31:0] epc;
        logic [31:0] imm;
        logic [31:0] rs1;
        logic        fl;
        logic [31:0] tgt;
        logic        mis;
    } vec_t;

    vec_t vt[NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_f, exp_d, tgt, h_pc, h_instr;
        bit          redir, hold;
        int          n_acc;

        vt[0] = '{1'b1, 2'd1, 32'h0000_0004, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_0024, 1'b0};
        vt[1] = '{1'b1, 2'd2, 32'h0,         32'h0000_0000, 32'h0000_0103, 1'b1, 32'h0000_0102, 1'b1};
        vt[2] = '{1'b1, 2'd1, 32'hFFFF_FFF0, 32'h0000_0020, 32'h0,         1'b1, 32'h0000_0010, 1'b0};
        vt[3] = '{1'b1, 2'd2, 32'h0,         32'h0000_0100, 32'h0000_0201, 1'b1, 32'h0000_0300, 1'b0};
        vt[4] = '{1'b1, 2'd0, 32'h0000_0040, 32'h0000_0040, 32'h0,         1'b0, RST_PC,        1'b0};
        vt[5] = '{1'b1, 2'd3, 32'h0000_0040, 32'h0000_0040, 32'h0000_0044, 1'b0, RST_PC,        1'b0};
        vt[6] = '{1'b0, 2'd1, 32'h0000_0040, 32'h0000_0040, 32'h0,         1'b0, RST_PC,        1'b0};
        vt[7] = '{1'b1, 2'd1, 32'h0000_1000, 32'hFFFF_FFFE, 32'h0,         1'b1, 32'h0000_0FFE, 1'b1};
        vt[8] = '{1'b1, 2'd2, 32'h0,         32'h0000_0008, 32'hFFFF_FFFC, 1'b1, 32'h0000_0004, 1'b0};

        // Redirect/target/misalign table, DUT parked in REQ with no grants
        for (int i = 0; i < NV; i++) begin
            gnt_pct = 0;
            do_reset();
            cyc();
            ex_valid = vt[i].ev;
            pc_src   = vt[i].src;
            ex_pc    = vt[i].epc;
            ex_imm   = vt[i].imm;
            ex_rs1   = vt[i].rs1;
            #3;
            chkb($sformatf("t%0d_flush", i), flush, vt[i].fl);
            cyc();
            ex_valid = 1'b0;
            #3;
            chkb($sformatf("t%0d_misalign", i), misalign, vt[i].mis);
            chkb($sformatf("t%0d_req", i), imem_req, !vt[i].mis);
            if (!vt[i].mis) begin
                chk($sformatf("t%0d_addr", i), imem_addr, vt[i].tgt);
            end else begin
                gnt_pct = 100;
                repeat (3) begin
                    cyc();
                    #3;
                    chkb($sformatf("t%0d_halt_req", i), imem_req, 1'b0);
                    chkb($sformatf("t%0d_halt_mis", i), misalign, 1'b1);
                end
            end
        end

        // Streaming with immediate grant and 1-cycle data, then decode stall
        gnt_pct = 100; lat_min = 1; lat_max = 1; id_ready = 1'b1;
        do_reset();
        for (int k = 1; k <= 2; k++) begin
            cyc(); #3;
            chkb("a_wait_req", imem_req, 1'b0);
            cyc(); #3;
            chkb("a_valid", if_valid, 1'b1);
            chk("a_pc", if_pc, 32'(4 * (k - 1)));
            chk("a_instr", if_instr, mem_word(32'(4 * (k - 1))));
            chkb("a_req", imem_req, 1'b1);
            chk("a_addr", imem_addr, 32'(4 * k));
        end
        cyc(); id_ready = 1'b0; #3;
        chkb("b_wait_req", imem_req, 1'b0);
        repeat (5) begin
            cyc(); #3;
            chkb("b_valid", if_valid, 1'b1);
            chk("b_pc", if_pc, 32'h8);
            chk("b_instr", if_instr, mem_word(32'h8));
            chkb("b_req", imem_req, 1'b0);
        end
        cyc(); id_ready = 1'b1; #3;
        chkb("b_resume_valid", if_valid, 1'b1);
        chk("b_resume_pc", if_pc, 32'h8);
        chkb("b_resume_req", imem_req, 1'b1);
        chk("b_resume_addr", imem_addr, 32'hC);

        // Redirect while waiting on a slow fetch of 0x8
        gnt_pct = 100; lat_min = 3; lat_max = 3; id_ready = 1'b1;
        do_reset();
        wait_gnt("c_g4");
        chk("c_addr4", imem_addr, 32'h4);
        wait_gnt("c_g8");
        chk("c_addr8", imem_addr, 32'h8);
        cyc();
        ex_valid = 1'b1; pc_src = 2'd1; ex_pc = 32'h4; ex_imm = 32'h20;
        #3;
        chkb("c_flush", flush, 1'b1);
        chkb("c_req", imem_req, 1'b0);
        wait_gnt("c_g24");
        chk("c_addr24", imem_addr, 32'h24);
        wait_valid("c_v24");
        chk("c_pc", if_pc, 32'h24);
        chk("c_instr", if_instr, mem_word(32'h24));

        // Redirect coincident with rvalid while decode stalls; wrapping target
        gnt_pct = 100; lat_min = 2; lat_max = 2; id_ready = 1'b0;
        do_reset();
        cyc();
        cyc();
        ex_valid = 1'b1; pc_src = 2'd1; ex_pc = 32'hFFFF_FFF0; ex_imm = 32'h20;
        #3;
        chkb("e_flush", flush, 1'b1);
        cyc();
        ex_valid = 1'b0;
        #3;
        chkb("e_valid", if_valid, 1'b0);
        chkb("e_req", imem_req, 1'b1);
        chk("e_addr", imem_addr, 32'h10);
        id_ready = 1'b1;
        wait_valid("e_v10");
        chk("e_pc", if_pc, 32'h10);
        chk("e_instr", if_instr, mem_word(32'h10));

        // Reset during WAIT; the stale response must be ignored
        gnt_pct = 100; lat_min = 3; lat_max = 3; id_ready = 1'b1;
        do_reset();
        cyc();
        rst_n = 1'b0; gnt_pct = 0; chk_inv = 1'b0;
        #3;
        chkb("f_rst_req", imem_req, 1'b0);
        chkb("f_rst_valid", if_valid, 1'b0);
        cyc();
        rst_n = 1'b1;
        #3;
        chkb("f_req", imem_req, 1'b1);
        chk("f_addr", imem_addr, RST_PC);
        cyc(); #3;
        cyc(); #3;
        chkb("f_stale_valid", if_valid, 1'b0);
        chkb("f_stale_req", imem_req, 1'b1);
        gnt_pct = 100; chk_inv = 1'b1;
        wait_gnt("f_g0");
        chk("f_gaddr", imem_addr, RST_PC);
        wait_valid("f_v0");
        chk("f_pc", if_pc, RST_PC);
        chk("f_instr", if_instr, mem_word(RST_PC));

        // Randomized traffic against a program-order model
        gnt_pct = 70; lat_min = 1; lat_max = 3; id_ready = 1'b1;
        do_reset();
        exp_f = RST_PC;
        exp_d = RST_PC;
        if (imem_req && imem_gnt) exp_f = exp_f + 32'd4;
        hold    = 1'b0;
        h_pc    = '0;
        h_instr = '0;
        n_acc   = 0;
        for (int c = 0; c < 1500; c++) begin
            cyc();
            id_ready = (int'($urandom_range(99)) < 70);
            ex_valid = (int'($urandom_range(99)) < 12);
            pc_src   = 2'($urandom_range(3));
            ex_pc    = $urandom & 32'hFFFF_FFFC;
            ex_rs1   = $urandom;
            if (pc_src == 2'd2)
                ex_imm = ($urandom & 32'hFFFF_FFFC) - ex_rs1 + 32'($urandom_range(1));
            else
                ex_imm = $urandom & 32'hFFFF_FFFC;
            #3;
            redir = ex_valid && (pc_src == 2'd1 || pc_src == 2'd2);
            tgt   = (pc_src == 2'd1) ? (ex_pc + ex_imm) : ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE);
            chkb("r_flush", flush, redir);
            if (hold) begin
                chkb("r_hold_valid", if_valid, 1'b1);
                chk("r_hold_pc", if_pc, h_pc);
                chk("r_hold_instr", if_instr, h_instr);
            end
            if (imem_req && imem_gnt) begin
                chk("r_fetch_addr", imem_addr, exp_f);
                exp_f = exp_f + 32'd4;
            end
            if (redir) begin
                exp_f = tgt;
                exp_d = tgt;
            end else if (if_valid && id_ready) begin
                chk("r_dec_pc", if_pc, exp_d);
                chk("r_dec_instr", if_instr, mem_word(exp_d));
                exp_d = exp_d + 32'd4;
                n_acc++;
            end
            hold    = if_valid && !id_ready && !redir;
            h_pc    = if_pc;
            h_instr = if_instr;
        end
        cyc();
        ex_valid = 1'b0;
        #3;
        chkb("r_liveness", n_acc >= 50, 1'b1);
        chkb("r_no_misalign", misalign, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
